md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core (successor to the single-cycle datapath; used in EX stage).
- Executes MULT/MULTU/DIV/DIVU with configurable latency, raises busy for stall logic, and supports MTHI/MTLO writes and an exception flush.
- Generalised in operand width and per-operation latency.

Parameters:
- WIDTH, 32, operand and HI/LO width (≥2)
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  operation request, sampled at rising edge
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 ignored
- A  in  WIDTH  rs operand; MTHI/MTLO source
- B  in  WIDTH  rt operand
- flush  in  1  cancel in-flight op (exception/eret), no HI/LO update
- busy  out  1  operation in flight
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clock/reset: one clock, clk; reset synchronous active-high. On reset: hi=0, lo=0, busy=0, counter=0, pending results discarded; this also applies mid-operation.
- Acceptance: an op is accepted at edge E0 when start=1, busy=0, flush=0, reset=0. If busy=1, start is ignored and no state changes (stall logic must hold via start|busy).
- MTHI/MTLO: on acceptance, hi (or lo) <= A at E0. busy stays 0. hi/lo are visible the next cycle.
- MULT/DIV: on acceptance, the result is computed from A/B sampled at E0 into internal hi_tmp/lo_tmp. counter <= N (MULT_CYCLES or DIV_CYCLES). busy=1 exactly N cycles, i.e. after E0 up to edge E_N. At E_N: hi<=hi_tmp, lo<=lo_tmp, busy falls. hi/lo keep old values while busy.
- busy is registered: busy = (counter != 0).
- Back-to-back ops: the op presented in the cycle after busy falls is accepted normally.
- Arithmetic:
  - MULT: signed A*B, 2*WIDTH product. hi = upper WIDTH bits, lo = lower.
  - MULTU: same, unsigned.
  - DIV: signed. lo = quotient truncated toward zero; hi = remainder with the sign of A.
  - DIVU: unsigned quotient/remainder.
  - Signed overflow (A = most-negative, B = −1): lo = most-negative, hi = 0.
  - Divide by zero (any div): lo = all ones, hi = A. Deterministic, no exception.
- Flush: when flush=1 at an edge, counter <= 0, busy <= 0, and the pending result is discarded. hi/lo keep their pre-op values. start in the same cycle is ignored, including MTHI/MTLO.
- Completion with flush on the same edge E_N: flush wins; hi/lo not updated.
- Reset priority over flush, flush over start.
- md_op 6/7 with start=1: no-op, busy stays 0.

Test Plan:
- MULT A=0xFFFFFFFE (−2), B=3, start 1 cycle -> busy high exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA after fall; hi/lo unchanged during busy.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=−7 (0xFFFFFFF9), B=2 -> busy 10 cycles; lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7. DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI A=0x12345678 -> hi=0x12345678 next cycle, busy never asserts. Start MTLO while a DIV is busy -> ignored; lo reflects only the DIV result.
- MULT started, flush at cycle 3 -> busy drops the next cycle; hi/lo keep prior values (e.g. 0xAAAA/0x5555). Flush exactly on the completion edge -> no update.
- Reset asserted mid-DIV (cycle 4) -> next cycle busy=0, hi=lo=0. Rerun with WIDTH=16, MULT_CYCLES=1: MULTU 0xFFFF*0xFFFF -> busy 1 cycle, hi=0xFFFE, lo=0x0001.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle MULT/DIV unit with HI/LO registers
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi_tmp;
    logic [WIDTH-1:0]   r_lo_tmp;

    logic [2*WIDTH-1:0] w_a_mul;
    logic [2*WIDTH-1:0] w_b_mul;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_div_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_b_safe;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both MULT and MULTU.
    always_comb begin
        if (md_op == OP_MULT) begin
            w_a_mul = {{WIDTH{A[WIDTH-1]}}, A};
            w_b_mul = {{WIDTH{B[WIDTH-1]}}, B};
        end else begin
            w_a_mul = {{WIDTH{1'b0}}, A};
            w_b_mul = {{WIDTH{1'b0}}, B};
        end
    end

    assign w_prod = w_a_mul * w_b_mul;

    // Signed divide runs on magnitudes; most-negative / -1 wraps back to most-negative naturally.
    assign w_div_signed = (md_op == OP_DIV);
    assign w_a_neg      = w_div_signed & A[WIDTH-1];
    assign w_b_neg      = w_div_signed & B[WIDTH-1];
    assign w_a_mag      = w_a_neg ? (~A + 1'b1) : A;
    assign w_b_mag      = w_b_neg ? (~B + 1'b1) : B;
    assign w_b_safe     = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_safe;
    assign w_r_mag      = w_a_mag % w_b_safe;

    always_comb begin
        w_div_hi = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;
        w_div_lo = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
        if (B == '0) begin
            w_div_hi = A;
            w_div_lo = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_hi_tmp <= '0;
            r_lo_tmp <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
            if (r_count == CW'(1)) begin
                r_hi <= r_hi_tmp;
                r_lo <= r_lo_tmp;
            end
        end else if (start) begin
            case (md_op)
                OP_MULT, OP_MULTU: begin
                    r_hi_tmp <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo_tmp <= w_prod[WIDTH-1:0];
                    r_count  <= CW'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    r_hi_tmp <= w_div_hi;
                    r_lo_tmp <= w_div_lo;
                    r_count  <= CW'(DIV_CYCLES);
                end
                OP_MTHI: r_hi <= A;
                OP_MTLO: r_lo <= A;
                default: ;
            endcase
        end
    end

    assign busy = (r_count != '0);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
